// File: rtl/gcm_host_seq.sv
// gcm_host_seq: host-side sequencer for an AES-GCM core.
// Latches a command and walks the core through hash-key setup, AAD blocks,
// data blocks (one outstanding at a time), the length block, and tag capture.
// Optional build macro: GCM_HOST_SEQ_TAG_CHECK_EN adds iExpTag/oAuthFail, a
// tag comparison reported in DONE for decrypt operations.
module gcm_host_seq (
    input  logic         iClk,
    input  logic         iRstn,
    // Command
    input  logic         iStart,
    input  logic         iEncdec,
    input  logic         iKeylen,
    input  logic [0:255] iKey,
    input  logic [0:95]  iIV,
    input  logic [7:0]   iAadCnt,
    input  logic [7:0]   iBlkCnt,
`ifdef GCM_HOST_SEQ_TAG_CHECK_EN
    input  logic [0:127] iExpTag,
`endif
    // Upstream data
    input  logic [0:127] iData,
    input  logic         iData_valid,
    output logic         oData_ready,
    // Core-facing
    output logic         oInit,
    output logic         oEncdec,
    output logic         oOpMode,
    output logic         oKeylen,
    output logic [0:255] oKey,
    output logic         oKey_valid,
    output logic [0:95]  oIV,
    output logic         oIV_valid,
    output logic [0:127] oAad,
    output logic         oAad_valid,
    output logic         oAad_last,
    output logic [0:127] oBlock,
    output logic         oBlock_valid,
    output logic         oBlock_last,
    input  logic         iCoreReady,
    input  logic [0:127] iResult,
    input  logic         iResult_valid,
    input  logic [0:127] iTag,
    input  logic         iTag_valid,
    // Downstream
    output logic [0:127] oOut,
    output logic         oOut_valid,
    output logic [0:127] oTagOut,
`ifdef GCM_HOST_SEQ_TAG_CHECK_EN
    output logic         oAuthFail,
`endif
    output logic         oDone,
    output logic         oBusy
);

    typedef enum logic [2:0] {
        StIdle,
        StHkey,
        StAad,
        StData,
        StWres,
        StTagw,
        StDone
    } state_e;

    state_e       r_state;
    state_e       w_state_nxt;

    logic         r_encdec;
    logic         r_keylen;
    logic [0:255] r_key;
    logic [0:95]  r_iv;
    logic         r_hkey_first;
    logic [7:0]   r_aad_cnt;   // AAD blocks still to accept
    logic [7:0]   r_blk_cnt;   // data blocks still to send
    logic [7:0]   r_aad_tot;   // latched totals, feed the length block
    logic [7:0]   r_blk_tot;
    logic [0:127] r_tag_out;

    logic         w_start;
    logic         w_aad_hs;
    logic         w_blk_hs;
    logic [0:127] w_len_blk;

    assign w_start  = (r_state == StIdle) && iStart;
    // Zero-count cycles never accept data, so a handshake needs a nonzero count.
    assign w_aad_hs = (r_state == StAad) && (r_aad_cnt != 8'd0) && iData_valid;
    assign w_blk_hs = (r_state == StData) && (r_blk_cnt != 8'd0) && iCoreReady && iData_valid;

    // Bit lengths: count * 128, zero-extended into two 64-bit fields.
    assign w_len_blk = {49'd0, r_aad_tot, 7'd0, 49'd0, r_blk_tot, 7'd0};

    // State register
    always_ff @(posedge iClk) begin
        if (!iRstn) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            StIdle: begin
                if (iStart) begin
                    w_state_nxt = StHkey;
                end
            end
            StHkey: begin
                // Core readiness is only honoured after the key/IV strobe cycle.
                if (!r_hkey_first && iCoreReady) begin
                    w_state_nxt = StAad;
                end
            end
            StAad: begin
                if (r_aad_cnt == 8'd0) begin
                    w_state_nxt = StData;
                end else if (w_aad_hs && (r_aad_cnt == 8'd1)) begin
                    w_state_nxt = StData;
                end
            end
            StData: begin
                if (r_blk_cnt == 8'd0) begin
                    w_state_nxt = StTagw;
                end else if (w_blk_hs) begin
                    w_state_nxt = StWres;
                end
            end
            StWres: begin
                if (iResult_valid) begin
                    w_state_nxt = (r_blk_cnt != 8'd0) ? StData : StTagw;
                end
            end
            StTagw: begin
                if (iTag_valid) begin
                    w_state_nxt = StDone;
                end
            end
            StDone: begin
                w_state_nxt = StIdle;
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    // Output decode
    always_comb begin
        oInit        = 1'b0;
        oKey_valid   = 1'b0;
        oIV_valid    = 1'b0;
        oData_ready  = 1'b0;
        oAad         = iData;
        oAad_valid   = 1'b0;
        oAad_last    = 1'b0;
        oBlock_valid = 1'b0;
        oBlock_last  = 1'b0;
        oOut_valid   = 1'b0;
        oDone        = 1'b0;
        oBusy        = (r_state != StIdle);
        case (r_state)
            StIdle: begin
                oBusy = 1'b0;
            end
            StHkey: begin
                oInit      = 1'b1;
                oKey_valid = r_hkey_first;
                oIV_valid  = r_hkey_first;
            end
            StAad: begin
                oInit = 1'b1;
                if (r_aad_cnt == 8'd0) begin
                    // No AAD: a bare last marker tells the core to move on.
                    oAad_last = 1'b1;
                end else begin
                    oData_ready = 1'b1;
                    oAad_valid  = w_aad_hs;
                    oAad_last   = w_aad_hs && (r_aad_cnt == 8'd1);
                end
            end
            StData: begin
                oInit = 1'b1;
                if (r_blk_cnt == 8'd0) begin
                    oBlock_last = 1'b1;
                end else begin
                    oData_ready  = iCoreReady;
                    oBlock_valid = w_blk_hs;
                    oBlock_last  = w_blk_hs && (r_blk_cnt == 8'd1);
                end
            end
            StWres: begin
                oInit      = 1'b1;
                oOut_valid = iResult_valid;
            end
            StTagw: begin
                oInit = 1'b1;
                oAad  = w_len_blk;
            end
            StDone: begin
                oDone = 1'b1;
            end
            default: begin
                oBusy = 1'b0;
            end
        endcase
    end

    // Control registers: command latch, counters, captured tag
    always_ff @(posedge iClk) begin
        if (!iRstn) begin
            r_encdec     <= 1'b0;
            r_keylen     <= 1'b0;
            r_hkey_first <= 1'b0;
            r_aad_cnt    <= 8'd0;
            r_blk_cnt    <= 8'd0;
            r_aad_tot    <= 8'd0;
            r_blk_tot    <= 8'd0;
            r_tag_out    <= '0;
        end else begin
            r_hkey_first <= w_start;
            if (w_start) begin
                r_encdec  <= iEncdec;
                r_keylen  <= iKeylen;
                r_aad_cnt <= iAadCnt;
                r_blk_cnt <= iBlkCnt;
                r_aad_tot <= iAadCnt;
                r_blk_tot <= iBlkCnt;
            end
            if (w_aad_hs) begin
                r_aad_cnt <= r_aad_cnt - 8'd1;
            end
            if (w_blk_hs) begin
                r_blk_cnt <= r_blk_cnt - 8'd1;
            end
            if ((r_state == StTagw) && iTag_valid) begin
                r_tag_out <= iTag;
            end
        end
    end

    // Key and IV are payload only and carry no reset
    always_ff @(posedge iClk) begin
        if (w_start) begin
            r_key <= iKey;
            r_iv  <= iIV;
        end
    end

`ifdef GCM_HOST_SEQ_TAG_CHECK_EN
    logic [0:127] r_exp_tag;

    // Expected tag is payload, latched with the command
    always_ff @(posedge iClk) begin
        if (w_start) begin
            r_exp_tag <= iExpTag;
        end
    end

    // Only decrypt is authenticated against a supplied tag
    assign oAuthFail = (r_state == StDone) && !r_encdec && (r_tag_out != r_exp_tag);
`endif

    assign oEncdec = r_encdec;
    assign oKeylen = r_keylen;
    assign oOpMode = 1'b0;
    assign oKey    = r_key;
    assign oIV     = r_iv;
    assign oBlock  = iData;
    assign oOut    = iResult;
    assign oTagOut = r_tag_out;

endmodule
